sram_port_arbiter: RTL

Arbitrates the core's instruction-fetch port and data load/store port onto one shared SRAM-like memory port with a request/addr_ok/data_ok handshake. It sits between the IF/EX/MEM stages and the single external memory interface. It keeps one transaction outstanding at a time and returns per-requester read data, completion pulses and stall requests for CTRL.

---
 rtl/sram_port_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one SRAM-like memory port (req / addr_ok / data_ok handshake)
// between the instruction-fetch port (I) and the data load/store port (D).
// One transaction is outstanding at a time. D wins when both ports request
// from IDLE. After each completion the other side is served next if it is
// waiting, so neither side can be starved.
//
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   i_req/i_addr                 fetch request (level) and address
//   i_rdata/i_valid/i_stallreq   fetched word, completion pulse, stall to CTRL
//   d_req/d_wen/d_addr/d_wdata   data request, byte enables (0 = load), operands
//   d_rdata/d_valid/d_stallreq   load data, completion pulse, stall to CTRL
//   m_req/m_wr/m_wstrb/m_addr/m_wdata   shared-port request side
//   m_addr_ok/m_data_ok/m_rdata         shared-port response side
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_valid,
  output logic                  i_stallreq,
  input  logic                  d_req,
  input  logic [DATA_W/8-1:0]   d_wen,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_valid,
  output logic                  d_stallreq,
  output logic                  m_req,
  output logic                  m_wr,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t              state;
  logic                owner_d;   // 1 = D owns the current transaction
  logic [ADDR_W-1:0]   lat_addr;
  logic [STRB_W-1:0]   lat_wen;
  logic [DATA_W-1:0]   lat_wdata;

  logic                grant;
  logic                grant_d;
  logic                complete;

  // Grant decision: fixed D priority from IDLE, alternation from RESP.
  // In RESP the owner's own req is still the completed request, so only
  // the other side may be granted.
  always_comb begin
    grant   = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (d_req) begin
          grant   = 1'b1;
          grant_d = 1'b1;
        end else if (i_req) begin
          grant = 1'b1;
        end
      end
      RESP: begin
        if (owner_d && i_req) begin
          grant = 1'b1;
        end else if (!owner_d && d_req) begin
          grant   = 1'b1;
          grant_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign complete = ((state == ADDR) && m_addr_ok && m_data_ok) ||
                    ((state == DATA) && m_data_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      lat_addr  <= '0;
      lat_wen   <= '0;
      lat_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_wstrb   <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant) begin
            owner_d   <= grant_d;
            lat_addr  <= grant_d ? d_addr : i_addr;
            lat_wen   <= grant_d ? d_wen : '0;
            lat_wdata <= grant_d ? d_wdata : '0;
            m_req     <= 1'b1;
            m_wr      <= grant_d & (|d_wen);
            m_wstrb   <= grant_d ? d_wen : '0;
            state     <= ADDR;
          end else begin
            state <= IDLE;
          end
        end
        ADDR: begin
          if (m_addr_ok) begin
            m_req   <= 1'b0;
            m_wr    <= 1'b0;
            m_wstrb <= '0;
            state   <= m_data_ok ? RESP : DATA;
          end
        end
        DATA: begin
          if (m_data_ok) state <= RESP;
        end
        default: state <= IDLE;
      endcase
      // Completion: pulse the owner's valid and capture read data.
      // Stores leave the owner's rdata register untouched.
      if (complete) begin
        if (owner_d) begin
          d_valid <= 1'b1;
          if (lat_wen == '0) d_rdata <= m_rdata;
        end else begin
          i_valid <= 1'b1;
          if (lat_wen == '0) i_rdata <= m_rdata;
        end
      end
    end
  end

  assign m_addr     = lat_addr;
  assign m_wdata    = lat_wdata;
  assign i_stallreq = i_req & ~i_valid;
  assign d_stallreq = d_req & ~d_valid;

endmodule
